lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 4: register width in bits.
REQ-003 Parameter TAPS, default 4'b1100: feedback tap mask, bit i set means q[i] enters the XOR (default is x^4+x^3+1).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load  input  1  load seed into register; level, sampled each edge.
REQ-007 seed  input  WIDTH  seed value captured on load.
REQ-008 run  input  1  start from IDLE/DONE; while high in RUN, permits shifting.
REQ-009 q  output  WIDTH  current LFSR state.
REQ-010 busy  output  1  high while in RUN.
REQ-011 period_done  output  1  one-cycle pulse when q returns to the captured seed.
REQ-012 period  output  WIDTH  shift count of the last completed cycle.
REQ-013 seed_err  output  1  sticky flag: zero seed loaded or run attempted with q==0.

Function
REQ-014 Feedback SHALL be fb = XOR of q[i] over all i with TAPS[i]=1; a shift SHALL be q <= {q[WIDTH-2:0], fb}.
REQ-015 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-016 load=1 in any state SHALL set q<=seed, capture seed internally, clear count, clear seed_err if seed!=0, set seed_err if seed==0, and go to IDLE; load SHALL win over run on the same edge.
REQ-017 IDLE or DONE with run=1, load=0, q!=0: go to RUN and perform the first shift on that same edge, count<=1.
REQ-018 IDLE or DONE with run=1 and q==0: stay in IDLE, set seed_err, q unchanged.
REQ-019 RUN with run=1: shift and increment count each edge; run=0 SHALL pause, with q and count held.
REQ-020 RUN, when the next q equals the captured seed: on that edge q<=seed, period<=count+1, period_done<=1 for exactly one cycle, go to DONE.
REQ-021 DONE SHALL hold q and period; a restart from DONE SHALL begin from the current q, which equals the seed.
REQ-022 busy SHALL be registered, equal to (state==RUN), and visible the cycle after the entering edge.
REQ-023 count and period SHALL be WIDTH bits; the period is at most 2^WIDTH-1, so no overflow handling is required.

Reset
REQ-024 rst=1 SHALL immediately force q=0, captured seed=0, count=0, period=0, period_done=0, busy=0, seed_err=0 and state IDLE, including in the middle of a run.
REQ-025 After reset, run with no prior load SHALL take the q==0 path of REQ-018.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration and default WIDTH/TAPS constants.
REQ-027 The q register SHALL be built from WIDTH instances of the team's async-reset single-bit flop sub-module dff; the FSM and counters are local.

Verification
REQ-028 Load seed=0001, pulse run -> q steps 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001; period_done on the 15th shift; period=15; DONE.
REQ-029 Load seed=0000, then run -> seed_err=1, state IDLE, q=0000, busy=0; load 0001 -> seed_err=0.
REQ-030 Start from seed 0001, drop run for 3 cycles after the 4th shift -> q holds 0011 for 3 cycles; completion still reports period=15.
REQ-031 load=1 and run=1 on the same edge with seed=0101 -> q=0101, IDLE, no shift, busy=0.
REQ-032 Assert rst asynchronously mid-RUN at q=0110 -> all outputs 0 before the next clk edge; state IDLE.
REQ-033 From DONE, pulse run -> a second full cycle from 0001 produces period=15 and one period_done pulse.

Source files
------------

// File: rtl/lfsr_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl_pkg
// Brief    : Shared types and default constants for the LFSR sequence
//            controller (FSM state enumeration, default width and taps).
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_seq_ctrl_pkg;

    // Default register width and feedback mask (x^4 + x^3 + 1).
    localparam int         DEFAULT_WIDTH = 4;
    localparam logic [3:0] DEFAULT_TAPS  = 4'b1100;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : lfsr_seq_ctrl_pkg
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module   : dff
// Brief    : Single-bit D flop, asynchronous active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d on every rising edge; reset forces 0 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule : dff
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl
// Brief    : Fibonacci LFSR with seed load, run/pause control and measurement
//            of the cycle length back to the captured seed.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl
    import lfsr_seq_ctrl_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             run,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             period_done,
    output logic [WIDTH-1:0] period,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    // Register state.
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_done_q, period_done_d;
    logic             busy_q, busy_d;
    logic             seed_err_q, seed_err_d;
    state_e           state_q, state_d;

    // Feedback and shifted value of the current state.
    logic             w_fb;
    logic [WIDTH-1:0] w_shifted;

    assign w_fb      = ^(q_q & TAPS);
    assign w_shifted = {q_q[WIDTH-2:0], w_fb};

    // The LFSR register itself is a row of single-bit flops.
    for (genvar i = 0; i < WIDTH; i++) begin : g_q_bits
        dff u_dff (
            .clk (clk),
            .rst (rst),
            .d   (q_d[i]),
            .q   (q_q[i])
        );
    end

    // Next-state logic: load beats run, otherwise the FSM decides shifting.
    always_comb begin
        q_d           = q_q;
        seed_d        = seed_q;
        count_d       = count_q;
        period_d      = period_q;
        period_done_d = 1'b0;
        seed_err_d    = seed_err_q;
        state_d       = state_q;

        if (load) begin
            q_d        = seed;
            seed_d     = seed;
            count_d    = C_ZERO;
            seed_err_d = (seed == C_ZERO);
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        if (q_q == C_ZERO) begin
                            // An all-zero register is a lock-up state.
                            seed_err_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            q_d     = w_shifted;
                            count_d = C_ONE;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (run) begin
                        if (w_shifted == seed_q) begin
                            q_d           = seed_q;
                            period_d      = count_q + C_ONE;
                            period_done_d = 1'b1;
                            state_d       = ST_DONE;
                        end else begin
                            q_d     = w_shifted;
                            count_d = count_q + C_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // FSM state, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            seed_q        <= C_ZERO;
            count_q       <= C_ZERO;
            period_q      <= C_ZERO;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
            seed_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            seed_q        <= seed_d;
            count_q       <= count_d;
            period_q      <= period_d;
            period_done_q <= period_done_d;
            busy_q        <= busy_d;
            seed_err_q    <= seed_err_d;
        end
    end

    assign q           = q_q;
    assign busy        = busy_q;
    assign period_done = period_done_q;
    assign period      = period_q;
    assign seed_err    = seed_err_q;

endmodule : lfsr_seq_ctrl
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_ctrl
// Brief    : Self-checking bench for lfsr_seq_ctrl: directed scenarios plus
//            randomized load/run/reset traffic against an orbit-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

    localparam int         WIDTH = 4;
    localparam logic [3:0] TAPS  = 4'b1100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             run = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             period_done;
    logic [WIDTH-1:0] period;
    logic             seed_err;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    lfsr_seq_ctrl #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .seed        (seed),
        .run         (run),
        .q           (q),
        .busy        (busy),
        .period_done (period_done),
        .period      (period),
        .seed_err    (seed_err)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model: the captured seed's orbit is enumerated on load,
    // and the model just walks a position index through it.
    // ------------------------------------------------------------------
    logic [3:0] m_orbit[$];
    int         m_pos;
    int         m_phase;      // 0 idle, 1 running, 2 finished
    logic [3:0] m_q;
    logic [3:0] m_period;
    logic       m_pulse;
    logic       m_err;

    function automatic logic [3:0] lfsr_next(input logic [3:0] x);
        int par = 0;
        for (int i = 0; i < WIDTH; i++)
            if (TAPS[i] && x[i]) par = par ^ 1;
        return 4'(((int'(x) * 2) % 16) + par);
    endfunction

    task automatic model_reset();
        m_orbit.delete();
        m_orbit.push_back(4'd0);
        m_pos    = 0;
        m_phase  = 0;
        m_q      = 4'd0;
        m_period = 4'd0;
        m_pulse  = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_load(input logic [3:0] s);
        logic [3:0] x;
        m_orbit.delete();
        m_orbit.push_back(s);
        x = lfsr_next(s);
        while (x != s && m_orbit.size() < 16) begin
            m_orbit.push_back(x);
            x = lfsr_next(x);
        end
    endtask

    task automatic model_step(input logic l, input logic [3:0] s, input logic r);
        m_pulse = 1'b0;
        if (l) begin
            model_load(s);
            m_q     = s;
            m_pos   = 0;
            m_phase = 0;
            m_err   = (s == 4'd0);
        end else if (m_phase != 1) begin
            if (r) begin
                if (m_q == 4'd0) begin
                    m_err   = 1'b1;
                    m_phase = 0;
                end else begin
                    m_pos   = 1;
                    m_q     = m_orbit[m_pos % m_orbit.size()];
                    m_phase = 1;
                end
            end
        end else if (r) begin
            if (m_pos + 1 == m_orbit.size()) begin
                m_q      = m_orbit[0];
                m_period = 4'(m_orbit.size());
                m_pulse  = 1'b1;
                m_phase  = 2;
                m_pos    = 0;
            end else begin
                m_pos++;
                m_q = m_orbit[m_pos];
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},           32'(q),           32'(m_q));
        check({tag, ".busy"},        32'(busy),        32'(m_phase == 1));
        check({tag, ".period_done"}, 32'(period_done), 32'(m_pulse));
        check({tag, ".period"},      32'(period),      32'(m_period));
        check({tag, ".seed_err"},    32'(seed_err),    32'(m_err));
    endtask

    // One clock: drive inputs, step model on the edge, compare 1 time unit later.
    task automatic cycle(input logic l, input logic [3:0] s, input logic r, input string tag);
        load = l;
        seed = s;
        run  = r;
        @(posedge clk);
        model_step(l, s, r);
        #1;
        if (period_done === 1'b1) pulse_cnt++;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    initial begin
        int p0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Run with no prior load takes the zero-register error path.
        cycle(0, 4'h0, 1, "run_no_load");

        // Full period from seed 0001.
        cycle(1, 4'h1, 0, "load1");
        p0 = pulse_cnt;
        for (int i = 0; i < 15; i++) begin
            cycle(0, 4'h0, 1, "seq");
            check("seq.const_q", 32'(q), 32'(exp_seq[i]));
        end
        check("seq.period15", 32'(period), 32'd15);
        check("seq.done_pulse", 32'(period_done), 32'd1);
        check("seq.pulses", 32'(pulse_cnt - p0), 32'd1);
        cycle(0, 4'h0, 0, "done_hold");
        check("done_hold.q", 32'(q), 32'h1);

        // Restart from DONE gives a second identical period.
        p0 = pulse_cnt;
        for (int i = 0; i < 15; i++) cycle(0, 4'h0, 1, "restart");
        cycle(0, 4'h0, 0, "restart_end");
        check("restart.period15", 32'(period), 32'd15);
        check("restart.pulses", 32'(pulse_cnt - p0), 32'd1);

        // Zero seed sets the sticky error; a good seed clears it.
        cycle(1, 4'h0, 0, "load0");
        cycle(0, 4'h0, 1, "run_zero");
        check("run_zero.err", 32'(seed_err), 32'd1);
        check("run_zero.busy", 32'(busy), 32'd0);
        cycle(1, 4'h1, 0, "reload1");
        check("reload1.err", 32'(seed_err), 32'd0);

        // Pause after the 4th shift.
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 1, "pause_pre");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'h0, 0, "pause");
            check("pause.q0011", 32'(q), 32'h3);
        end
        for (int i = 0; i < 11; i++) cycle(0, 4'h0, 1, "pause_post");
        check("pause.period15", 32'(period), 32'd15);

        // Load and run on the same edge: load wins.
        cycle(1, 4'h5, 1, "load_run");
        check("load_run.q", 32'(q), 32'h5);
        check("load_run.busy", 32'(busy), 32'd0);

        // Async reset mid-run at q=0110.
        cycle(1, 4'h1, 0, "rst_load");
        for (int i = 0; i < 5; i++) cycle(0, 4'h0, 1, "rst_run");
        check("rst_run.q0110", 32'(q), 32'h6);
        async_reset("async_rst");
        check("async_rst.q", 32'(q), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       l, r;
            logic [3:0] s;
            l = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 3) != 0);
            s = 4'($urandom_range(0, 15));
            cycle(l, s, r, "rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lfsr_seq_ctrl
`default_nettype wire
